// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive path (and the matching Tx side):
//   - rx_state_e      : receive FSM state encoding
//   - DATA_BITS       : payload width of one frame
//   - DEFAULT_CLK_FREQ / DEFAULT_BAUD_RATE : common default line setup
//   - calc_clks_per_bit() : clk cycles per serial bit
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS         = 8;
   localparam int DEFAULT_CLK_FREQ  = 50_000_000;
   localparam int DEFAULT_BAUD_RATE = 115_200;

   // Encodings are fixed so that debug views of the state stay stable
   // between the parity and non-parity builds.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

   // Integer division truncates: 50 MHz / 115200 gives 434.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_bps_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_bps_counter
// Per-bit cycle counter for the UART receiver. Counts clk cycles while
// enabled and raises a one-cycle tick on the cycle whose rising edge ends a
// half bit (i_half = 1) or a full bit (i_half = 0). The count wraps to zero on
// the tick edge, so consecutive full-bit ticks are CLKS_PER_BIT cycles apart.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_clear   : force the count to zero (has priority over counting)
//   i_enable  : count this cycle
//   i_half    : 1 selects the half-bit interval, 0 the full-bit interval
//   o_tick    : combinational tick, consumed by the FSM on the next edge
// -----------------------------------------------------------------------------
module uart_rx_bps_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_half,
   output logic o_tick
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int                HALF      = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last;

   // o_tick deliberately ignores i_clear: the FSM derives i_clear from its
   // next state, which itself depends on o_tick.
   always_comb begin
      last   = i_half ? HALF_LAST : FULL_LAST;
      o_tick = i_enable && (cnt_q == last);
      cnt_d  = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start, 8 data (LSB first), optional even parity, 1 stop.
// The line is double-flopped, bits are sampled at mid-bit, and each finished
// frame produces exactly one one-cycle strobe. Strobes are valid-only (no
// ready): the consumer must capture o_rx_d in the strobe cycle or later,
// o_rx_d holding until the next frame completes.
// Build macro: UART_RX_PARITY_EN compiles in the PARITY state (11-bit frame).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_rx_d           : serial line, idle high, asynchronous to clk
//   o_rx_d           : last received byte
//   o_rx_valid       : strobe, new error-free byte on o_rx_d
//   o_rx_frame_err   : strobe, stop bit sampled low
//   o_rx_parity_err  : strobe, parity mismatch (constant 0 without parity)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
   parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx_d,
   output logic [DATA_BITS-1:0] o_rx_d,
   output logic                 o_rx_valid,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_parity_err
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

   rx_state_e              state_q, state_d;
   logic                   rx_meta_q, rx_meta_d;
   logic                   rx_sync_q, rx_sync_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                   parity_q, parity_d;
   logic                   perr_q, perr_d;
`endif

   logic cnt_clear, cnt_en, cnt_half, tick;

   uart_rx_bps_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bps_counter (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (cnt_clear),
      .i_enable (cnt_en),
      .i_half   (cnt_half),
      .o_tick   (tick)
   );

   always_comb begin
      rx_meta_d = i_rx_d;
      rx_sync_d = rx_meta_q;
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      rx_data_d = rx_data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_d  = parity_q;
      perr_d    = 1'b0;
`endif
      cnt_en    = 1'b0;
      cnt_half  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) state_d = ST_START;
         end
         ST_START: begin
            cnt_en   = 1'b1;
            cnt_half = 1'b1;
            if (tick) begin
               // A line back high at mid-start is a glitch, not a frame.
               if (!rx_sync_q) begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            cnt_en = 1'b1;
            if (tick) begin
               shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            cnt_en = 1'b1;
            if (tick) begin
               parity_d = rx_sync_q;
               state_d  = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            cnt_en = 1'b1;
            if (tick) begin
               rx_data_d = shift_q;
               if (rx_sync_q) begin
                  // Leaving at mid-stop lets a back-to-back start bit be seen.
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (^{shift_q, parity_q} == 1'b0) valid_d = 1'b1;
                  else                              perr_d  = 1'b1;
`else
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line must go high before another frame is accepted.
            if (rx_sync_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      cnt_clear = (state_d != state_q) || (state_q == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         shift_q   <= '0;
         bit_idx_q <= '0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q  <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_meta_d;
         rx_sync_q <= rx_sync_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         parity_q  <= parity_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign o_rx_d         = rx_data_q;
   assign o_rx_valid     = valid_q;
   assign o_rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign o_rx_parity_err = perr_q;
`else
   assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART Tx path, consuming the serial line that a UART transmitter drives. Synchronises the asynchronous line input and detects a start bit. Samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents the byte with a one-cycle valid strobe. Fixed format is 1 start, 8 data, 1 stop bit at 115200 baud, with an optional even parity bit.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), derived localparam; must be ≥ 4
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- i_rx_d  input  1  serial line, idle high, asynchronous to clk
- o_rx_d  output  8  last received byte
- o_rx_valid  output  1  one-cycle strobe: o_rx_d holds a new, error-free byte
- o_rx_frame_err  output  1  one-cycle strobe: stop bit sampled low
- o_rx_parity_err  output  1  one-cycle strobe: parity mismatch (tied 0 without parity)

## Operation
- The synchroniser is 2 flops on i_rx_d, both resetting to 1. The FSM sees only the synchronised line.
- HALF = CLKS_PER_BIT/2 (217).
- The bit counter counts clk cycles. It clears on every state transition and on each sample.
- FSM states are IDLE, START, DATA, PARITY (parity build only), STOP, BREAK.
  - IDLE: synchronised line low → START.
  - START: sample when the counter reaches HALF. Low → DATA. High → IDLE (glitch rejected, no strobe).
  - DATA: sample every CLKS_PER_BIT cycles. Shift right with the sample inserted at bit 7, so the first bit received ends in bit 0. A 3-bit index counts 0..7; after bit 7 go to PARITY or STOP.
  - PARITY: sample after CLKS_PER_BIT cycles → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High, parity ok: load o_rx_d, pulse o_rx_valid → IDLE.
    - High, parity bad: load o_rx_d, pulse o_rx_parity_err, no valid → IDLE.
    - Low: load o_rx_d, pulse o_rx_frame_err, no valid, parity not reported → BREAK.
  - BREAK: wait for the synchronised line high → IDLE. This prevents a held-low line from being read as repeated frames.
- Returning to IDLE at mid-stop-bit allows a back-to-back start bit to be detected with no dead time.
- o_rx_d holds its value until the next frame completes, with or without an error.
- At most one strobe is asserted in any cycle.

## Timing
- Reset values: o_rx_d = 8'h00; all strobes 0; FSM IDLE; synchroniser 1s; counters 0.
- Reset mid-frame abandons the frame immediately. No strobe is issued. Reception restarts only on a new falling edge after reset deasserts.
- Edge numbering: edge 0 is the first rising clk edge that captures i_rx_d low.
  - START entered at edge 2.
  - Start sample at edge 2+HALF.
  - Data bit i sample at edge 2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample at edge 2+HALF+9·CLKS_PER_BIT; 10·CLKS_PER_BIT with parity.
- Strobes are registered at the stop-sample edge and high for exactly that one cycle.
- Default latency to o_rx_valid is edge 4125, or 4559 with parity.
- Glitches shorter than HALF cycles produce no output.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is compiled in; the frame is 11 bits.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0, otherwise o_rx_parity_err.
- Undefined:
  - No PARITY state; the frame is 10 bits.
  - o_rx_parity_err is a constant 0; the port list is unchanged.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - DATA_BITS = 8;
  - default CLK_FREQ and BAUD_RATE constants shared with the Tx side;
  - a function computing CLKS_PER_BIT.
- One sub-module: uart_rx_bps_counter, the per-bit cycle counter.
  - Inputs: clear, enable, half-bit/full-bit select.
  - Output: one-cycle sample tick.
- The synchroniser, shift register and FSM stay in uart_rx.

## Test plan
- Frame 8'hA5 at 434 clk/bit → o_rx_d = 8'hA5 and o_rx_valid high for one cycle at edge 4125; no error strobes.
- Back-to-back 8'h00 then 8'hFF with no idle gap → two valid strobes 4340 cycles apart, o_rx_d = 8'h00 then 8'hFF.
- 100-cycle low glitch on an idle line → no strobes, FSM back in IDLE.
- Frame 8'h3C with stop bit 0 and the line held low 2000 further cycles → o_rx_frame_err once, o_rx_d = 8'h3C, no o_rx_valid. Next frame 8'h11 after the line returns high → received correctly.
- rst asserted during data bit 4 of 8'h5A → all outputs at reset values, no strobe. Following frame 8'h5A → received correctly.
- With UART_RX_PARITY_EN: 8'h01 with parity bit 0 → o_rx_parity_err only. 8'h01 with parity bit 1 → o_rx_valid at edge 4559.
